// File: rtl/operand_read_if.sv
// Handshake and data bundle between decode/writeback and the operand-read stage.
// The master side drives writeback and issue fields; the slave side returns stall and operands.
interface operand_read_if;
    logic        regwr;
    logic [4:0]  rw;
    logic [31:0] busW;
    logic [1:0]  fpoint;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        rafp;
    logic        rbfp;
    logic        ren_a;
    logic        ren_b;
    logic        issue;
    logic [4:0]  dest;
    logic        destfp;
    logic        destwr;
    logic        stall;
    logic        qvalid;
    logic [31:0] busA;
    logic [31:0] busB;

    modport master (
        output regwr, rw, busW, fpoint,
        output ra, rb, rafp, rbfp, ren_a, ren_b,
        output issue, dest, destfp, destwr,
        input  stall, qvalid, busA, busB
    );

    modport slave (
        input  regwr, rw, busW, fpoint,
        input  ra, rb, rafp, rbfp, ren_a, ren_b,
        input  issue, dest, destfp, destwr,
        output stall, qvalid, busA, busB
    );
endinterface

// File: rtl/operand_read.sv
// Operand-read stage: integer and FP register files, a pending-write scoreboard,
// write-through bypass from writeback, and a registered operand output.
module operand_read (
    input  logic           clk,
    input  logic           reset,
    operand_read_if.slave  bus
);

    logic [31:0] rf_int [32];
    logic [31:0] rf_fp  [32];
    logic [31:0] pend_int;
    logic [31:0] pend_fp;

    logic        wr_int;
    logic        wr_fp;
    logic        wbhit_a;
    logic        wbhit_b;
    logic        pend_a;
    logic        pend_b;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        accept;
    logic [31:0] clr_int;
    logic [31:0] clr_fp;
    logic [31:0] set_int;
    logic [31:0] set_fp;

    // Integer r0 is hardwired, so writes to it are dropped before they reach
    // the file, the bypass or the scoreboard.
    assign wr_int = bus.regwr && (bus.fpoint == 2'b00) && (bus.rw != 5'd0);
    assign wr_fp  = bus.regwr && (bus.fpoint == 2'b01);

    assign wbhit_a = bus.rafp ? (wr_fp && (bus.rw == bus.ra))
                              : (wr_int && (bus.rw == bus.ra));
    assign wbhit_b = bus.rbfp ? (wr_fp && (bus.rw == bus.rb))
                              : (wr_int && (bus.rw == bus.rb));

    assign pend_a = bus.rafp ? pend_fp[bus.ra] : pend_int[bus.ra];
    assign pend_b = bus.rbfp ? pend_fp[bus.rb] : pend_int[bus.rb];

    always_comb begin
        rd_a = 32'd0;
        if (!bus.rafp && (bus.ra == 5'd0))
            rd_a = 32'd0;
        else if (wbhit_a)
            rd_a = bus.busW;
        else if (bus.rafp)
            rd_a = rf_fp[bus.ra];
        else
            rd_a = rf_int[bus.ra];
    end

    always_comb begin
        rd_b = 32'd0;
        if (!bus.rbfp && (bus.rb == 5'd0))
            rd_b = 32'd0;
        else if (wbhit_b)
            rd_b = bus.busW;
        else if (bus.rbfp)
            rd_b = rf_fp[bus.rb];
        else
            rd_b = rf_int[bus.rb];
    end

    assign bus.stall = (bus.ren_a && pend_a && !wbhit_a) ||
                       (bus.ren_b && pend_b && !wbhit_b);
    assign accept    = bus.issue && !bus.stall;

    always_comb begin
        clr_int = 32'd0;
        clr_fp  = 32'd0;
        set_int = 32'd0;
        set_fp  = 32'd0;
        if (wr_int)
            clr_int[bus.rw] = 1'b1;
        if (wr_fp)
            clr_fp[bus.rw] = 1'b1;
        if (accept && bus.destwr) begin
            if (bus.destfp)
                set_fp[bus.dest] = 1'b1;
            else if (bus.dest != 5'd0)
                set_int[bus.dest] = 1'b1;
        end
    end

    // Set is applied after clear: an issuing producer is newer than the
    // retiring one, so it owns the register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_int[i] <= 32'd0;
                rf_fp[i]  <= 32'd0;
            end
            pend_int   <= 32'd0;
            pend_fp    <= 32'd0;
            bus.qvalid <= 1'b0;
            bus.busA   <= 32'd0;
            bus.busB   <= 32'd0;
        end else begin
            if (wr_int)
                rf_int[bus.rw] <= bus.busW;
            if (wr_fp)
                rf_fp[bus.rw] <= bus.busW;
            pend_int <= (pend_int & ~clr_int) | set_int;
            pend_fp  <= (pend_fp & ~clr_fp) | set_fp;
            bus.qvalid <= accept;
            if (accept) begin
                bus.busA <= rd_a;
                bus.busB <= rd_b;
            end
        end
    end

endmodule
